// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M divide/remainder unit.
//   mdu_op_t    : 2-bit divide opcode (bit 1 selects remainder, bit 0 selects unsigned)
//   div_state_t : divider FSM states
//   DIV_ZERO_Q  : quotient returned for a zero divisor
//   INT_MIN     : most negative 32-bit value, the signed-overflow dividend
package mdu_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } mdu_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFixup,
    StDone
  } div_state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract the divisor
// from the upper (XLEN+1)-bit part and keep the difference when it is non-negative.
//   rem_i/quo_i : current partial remainder and quotient/dividend shift register
//   divisor_i   : unsigned divisor magnitude
//   rem_o/quo_o : next partial remainder and quotient
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [2*XLEN:0] shifted;
  logic [XLEN:0]   trial;

  // The remainder never reaches the divisor, so its MSB is always shifted out as zero.
  assign shifted = {rem_i, quo_i} << 1;
  assign trial   = shifted[2*XLEN:XLEN] - {1'b0, divisor_i};

  always_comb begin
    rem_o = trial[XLEN] ? shifted[2*XLEN:XLEN] : trial;
    quo_o = shifted[XLEN-1:0] | {{(XLEN-1){1'b0}}, ~trial[XLEN]};
  end

endmodule

// File: rtl/mdu_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit using the execute-stage stall handshake.
//   clk, Rst_n     : clock, asynchronous active-low reset
//   start, op      : request and opcode, sampled only in idle
//   rs1, rs2       : dividend and divisor, sampled with start
//   kill           : flush, aborts any operation without producing a result
//   mem_hold       : freeze, keeps the finished result presented
//   stall          : execute must not advance
//   res, res_valid : registered result and one-cycle (or held) valid
//   busy           : FSM is not idle
module mdu_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            Rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  input  logic            mem_hold,
  output logic            stall,
  output logic [XLEN-1:0] res,
  output logic            res_valid,
  output logic            busy
);

  div_state_t      state_q;
  mdu_op_t         op_q;
  logic [XLEN-1:0] a_q, b_q, quo_q, res_q;
  logic [XLEN:0]   rem_q;
  logic [4:0]      cnt_q;
  logic            qneg_q, rneg_q, valid_q;

  logic            signed_op, div_zero, overflow;
  logic [XLEN-1:0] abs_a, abs_b, q_fix, r_fix, step_quo;
  logic [XLEN:0]   step_rem;

  assign signed_op = ~op_q[0];
  assign abs_a     = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b     = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;
  assign div_zero  = (b_q == '0);
  assign overflow  = signed_op && (a_q == INT_MIN) && (b_q == '1);
  assign q_fix     = qneg_q ? -quo_q : quo_q;
  assign r_fix     = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(b_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      op_q    <= OpDiv;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else if (kill) begin
      // Abort wins over everything; the previous result stays on res.
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (start) begin
            op_q    <= mdu_op_t'(op);
            a_q     <= rs1;
            b_q     <= rs2;
            state_q <= StPrep;
          end
        end
        StPrep: begin
          if (div_zero) begin
            res_q   <= op_q[1] ? a_q : DIV_ZERO_Q;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else if (overflow) begin
            res_q   <= op_q[1] ? '0 : INT_MIN;
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            rem_q   <= '0;
            quo_q   <= abs_a;
            b_q     <= abs_b;
            cnt_q   <= '0;
            qneg_q  <= signed_op & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            rneg_q  <= signed_op & a_q[XLEN-1];
            state_q <= StCalc;
          end
        end
        StCalc: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) state_q <= StFixup;
        end
        StFixup: begin
          res_q   <= op_q[1] ? r_fix : q_fix;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (!mem_hold) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall     = ((state_q == StIdle) && start && !kill) || (state_q == StPrep) ||
                     (state_q == StCalc) || (state_q == StFixup);
  assign busy      = (state_q != StIdle);
  assign res       = res_q;
  assign res_valid = valid_q;

endmodule

// File: tb/tb_mdu_div_unit.sv
// Directed bench for mdu_div_unit: arithmetic reference model plus a per-cycle compare process.
module tb_mdu_div_unit;

  logic        clk = 1'b0;
  logic        Rst_n, start, kill, mem_hold;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        stall, res_valid, busy;
  logic [31:0] res;

  int          n_vec = 0;
  int          n_err = 0;
  int          pending = 0;
  logic [31:0] exp_res = '0;

  mdu_div_unit #(
    .XLEN(32),
    .ITER(32)
  ) dut (
    .clk      (clk),
    .Rst_n    (Rst_n),
    .start    (start),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .kill     (kill),
    .mem_hold (mem_hold),
    .stall    (stall),
    .res      (res),
    .res_valid(res_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Reference results straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Compare process: every new result against the model, held results for stability.
  initial begin : compare
    logic        prev_v;
    logic [31:0] held;
    prev_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (!Rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (res_valid && !prev_v) begin
          if (pending <= 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: res_valid=1 res=%h, expected no result", res);
          end else begin
            pending--;
            chk("model_result", res, exp_res);
          end
          held = res;
        end else if (res_valid) begin
          chk("held_result", res, held);
        end
        prev_v = res_valid;
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, b,
                        input logic [31:0] lit, input int hold);
    int   lat, nst, k, nv;
    bit   got;
    lat = is_special(o, a, b) ? 1 : 34;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    exp_res = model(o, a, b);
    pending++;
    @(posedge clk);
    #1 start = 1'b0;
    nst = 0; got = 0; k = 0;
    while (k < 100 && !got) begin
      @(negedge clk);
      if (res_valid) got = 1;
      else begin
        if (stall) nst++;
        k++;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no res_valid within 100 cycles, expected latency %0d", name, lat);
      pending = 0;
      return;
    end
    chk({name, "_latency"}, k, lat);
    chk({name, "_stall_cycles"}, nst, lat);
    chk({name, "_res"}, res, lit);
    chk({name, "_stall_in_done"}, {31'b0, stall}, 32'd0);
    if (hold > 0) begin
      mem_hold = 1'b1;
      nv = 1;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        if (res_valid) nv++;
        if (j == hold - 1) mem_hold = 1'b0;
      end
      chk({name, "_hold_valid_cycles"}, nv, hold + 1);
      @(negedge clk);
      chk({name, "_valid_after_hold"}, {31'b0, res_valid}, 32'd0);
      chk({name, "_busy_after_hold"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin : stim
    logic [31:0] old_res;
    logic [5:0]  exp_v;
    int          nv;
    Rst_n = 1'b1; start = 1'b0; kill = 1'b0; mem_hold = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    #1 Rst_n = 1'b0;
    #2;
    chk("reset_res", res, 32'd0);
    chk("reset_valid", {31'b0, res_valid}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    Rst_n = 1'b1;

    // Pin the reference model itself.
    chk("model_div_neg", model(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model_rem_neg", model(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model_rem_div0", model(2'b10, 32'd5, 32'd0), 32'd5);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 0);
    run_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("remu_min_3", 2'b11, 32'h8000_0000, 32'd3, 32'd2, 0);
    run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 0);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Kill in the 10th CALC cycle.
    @(negedge clk);
    op = 2'b01; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
    exp_res = model(2'b01, 32'd1000, 32'd7);
    pending++;
    old_res = res;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    kill = 1'b1;
    pending = 0;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_stall_next", {31'b0, stall}, 32'd0);
    chk("kill_busy_next", {31'b0, busy}, 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (res_valid) nv++;
    end
    chk("kill_no_valid", nv, 0);
    chk("kill_res_kept", res, old_res);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 0);

    // Held result under mem_hold.
    run_op("hold_divu_50_5", 2'b01, 32'd50, 32'd5, 32'd10, 4);

    // start held high: second acceptance only from idle, one cycle after done.
    @(negedge clk);
    op = 2'b01; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1;
    exp_res = model(2'b01, 32'd5, 32'd0);
    pending += 2;
    exp_v = 6'b010010;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_valid_k%0d", k), {31'b0, res_valid}, {31'b0, exp_v[k]});
      if (k == 2) begin
        chk("b2b_busy_idle", {31'b0, busy}, 32'd0);
        chk("b2b_stall_idle", {31'b0, stall}, 32'd1);
      end
      if (k == 4) start = 1'b0;
    end
    chk("b2b_all_consumed", pending, 0);
    pending = 0;

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    exp_res = model(2'b01, 32'd1000, 32'd3);
    pending++;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 Rst_n = 1'b0;
    pending = 0;
    #1;
    chk("arst_res", res, 32'd0);
    chk("arst_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    Rst_n = 1'b1;
    run_op("divu_8_2", 2'b01, 32'd8, 32'd2, 32'd4, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
